// File: rtl/block_chk_pkg.sv
// Shared types and character constants for the begin/end nesting checker.
// Both the word matcher and the depth tracker import this package.
package block_chk_pkg;

    typedef enum logic [3:0] {
        WS_SEP   = 4'd0,
        WS_B     = 4'd1,
        WS_BE    = 4'd2,
        WS_BEG   = 4'd3,
        WS_BEGI  = 4'd4,
        WS_BEGIN = 4'd5,
        WS_E     = 4'd6,
        WS_EN    = 4'd7,
        WS_END   = 4'd8,
        WS_OTHER = 4'd9
    } word_state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        KW_BEGIN = 2'd1,
        KW_END   = 2'd2
    } kw_class_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B_UC  = 8'h42;
    localparam logic [7:0] CH_B_LC  = 8'h62;
    localparam logic [7:0] CH_E_UC  = 8'h45;
    localparam logic [7:0] CH_E_LC  = 8'h65;
    localparam logic [7:0] CH_G_UC  = 8'h47;
    localparam logic [7:0] CH_G_LC  = 8'h67;
    localparam logic [7:0] CH_I_UC  = 8'h49;
    localparam logic [7:0] CH_I_LC  = 8'h69;
    localparam logic [7:0] CH_N_UC  = 8'h4E;
    localparam logic [7:0] CH_N_LC  = 8'h6E;
    localparam logic [7:0] CH_D_UC  = 8'h44;
    localparam logic [7:0] CH_D_LC  = 8'h64;

    // Lowercase always matches; uppercase only when case-insensitive.
    function automatic logic char_is(input logic [7:0] ch,
                                     input logic [7:0] uc,
                                     input logic [7:0] lc,
                                     input logic       case_sens);
        return (ch == lc) || (!case_sens && (ch == uc));
    endfunction

endpackage

// File: rtl/block_nest_checker_if.sv
// Character stream into the keyword matcher and its pending-word report back.
// The checker drives the character side; the matcher drives the report.
interface block_nest_checker_if;
    import block_chk_pkg::*;

    logic       in_valid;
    logic [7:0] in;
    kw_class_e  pend_class;
    logic       commit;

    modport master (output in_valid, in, input pend_class, commit);
    modport slave  (input in_valid, in, output pend_class, commit);

endinterface

// File: rtl/block_nest_checker_kw_matcher.sv
// Word FSM: follows the "begin"/"end" prefixes character by character and
// raises a commit strobe when a separator closes a non-empty word.
module kw_matcher
    import block_chk_pkg::*;
#(
    parameter int CASE_SENS = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    block_nest_checker_if.slave  kw
);

    localparam logic CS = (CASE_SENS != 0) ? 1'b1 : 1'b0;

    word_state_e state_q;
    word_state_e state_d;
    kw_class_e   pend_s;
    logic        is_sep_s;

    assign is_sep_s = (kw.in == CH_SPACE);

    // Next word state; any miss, or a letter after a full keyword, lands in OTHER.
    always_comb begin
        state_d = state_q;
        if (!kw.in_valid) begin
            state_d = state_q;
        end else if (is_sep_s) begin
            state_d = WS_SEP;
        end else begin
            case (state_q)
                WS_SEP: begin
                    if (char_is(kw.in, CH_B_UC, CH_B_LC, CS)) begin
                        state_d = WS_B;
                    end else if (char_is(kw.in, CH_E_UC, CH_E_LC, CS)) begin
                        state_d = WS_E;
                    end else begin
                        state_d = WS_OTHER;
                    end
                end
                WS_B:    state_d = char_is(kw.in, CH_E_UC, CH_E_LC, CS) ? WS_BE    : WS_OTHER;
                WS_BE:   state_d = char_is(kw.in, CH_G_UC, CH_G_LC, CS) ? WS_BEG   : WS_OTHER;
                WS_BEG:  state_d = char_is(kw.in, CH_I_UC, CH_I_LC, CS) ? WS_BEGI  : WS_OTHER;
                WS_BEGI: state_d = char_is(kw.in, CH_N_UC, CH_N_LC, CS) ? WS_BEGIN : WS_OTHER;
                WS_E:    state_d = char_is(kw.in, CH_N_UC, CH_N_LC, CS) ? WS_EN    : WS_OTHER;
                WS_EN:   state_d = char_is(kw.in, CH_D_UC, CH_D_LC, CS) ? WS_END   : WS_OTHER;
                default: state_d = WS_OTHER;
            endcase
        end
    end

    // Word state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WS_SEP;
        end else begin
            state_q <= state_d;
        end
    end

    // Classify the word currently being assembled.
    always_comb begin
        pend_s = NONE;
        case (state_q)
            WS_BEGIN: pend_s = KW_BEGIN;
            WS_END:   pend_s = KW_END;
            default:  pend_s = NONE;
        endcase
    end

    assign kw.pend_class = pend_s;
    assign kw.commit     = kw.in_valid && is_sep_s && (state_q != WS_SEP);

endmodule

// File: rtl/block_nest_checker.sv
// Begin/end nesting checker: keeps the committed depth and sticky error flags,
// and reports whether the stream would be balanced if it ended right now.
module block_nest_checker
    import block_chk_pkg::*;
#(
    parameter int DEPTH_W   = 8,
    parameter int MAX_DEPTH = 255,
    parameter int CASE_SENS = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_unmatched,
    output logic               err_overflow
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = DEPTH_W'(0);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               err_unm_q;
    logic               err_unm_d;
    logic               err_ovf_q;
    logic               err_ovf_d;
    logic               frozen_s;
    logic [DEPTH_W-1:0] eff_s;
    logic               forced_zero_s;
    logic               result_s;

    block_nest_checker_if kw_bus ();

    assign kw_bus.in_valid = in_valid;
    assign kw_bus.in       = in;

    kw_matcher #(
        .CASE_SENS (CASE_SENS)
    ) u_kw_matcher (
        .clk   (clk),
        .reset (reset),
        .kw    (kw_bus)
    );

    assign frozen_s = err_unm_q || err_ovf_q;

    // Apply a committed keyword; increments/decrements are guarded so depth never wraps.
    always_comb begin
        depth_d   = depth_q;
        err_unm_d = err_unm_q;
        err_ovf_d = err_ovf_q;
        if (kw_bus.commit) begin
            case (kw_bus.pend_class)
                KW_BEGIN: begin
                    if (depth_q == DEPTH_MAX) begin
                        err_ovf_d = 1'b1;
                    end else if (!frozen_s) begin
                        depth_d = depth_q + DEPTH_ONE;
                    end else begin
                        depth_d = depth_q;
                    end
                end
                KW_END: begin
                    if (depth_q == DEPTH_ZERO) begin
                        err_unm_d = 1'b1;
                    end else if (!frozen_s) begin
                        depth_d = depth_q - DEPTH_ONE;
                    end else begin
                        depth_d = depth_q;
                    end
                end
                default: depth_d = depth_q;
            endcase
        end else begin
            depth_d = depth_q;
        end
    end

    // Depth and sticky error registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q   <= DEPTH_ZERO;
            err_unm_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            depth_q   <= depth_d;
            err_unm_q <= err_unm_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Effective depth if the stream ended now, including the pending word.
    always_comb begin
        eff_s         = depth_q;
        forced_zero_s = 1'b0;
        case (kw_bus.pend_class)
            KW_BEGIN: begin
                if (depth_q == DEPTH_MAX) begin
                    forced_zero_s = 1'b1;
                    eff_s         = depth_q;
                end else begin
                    eff_s = depth_q + DEPTH_ONE;
                end
            end
            KW_END: begin
                if (depth_q == DEPTH_ZERO) begin
                    forced_zero_s = 1'b1;
                    eff_s         = depth_q;
                end else begin
                    eff_s = depth_q - DEPTH_ONE;
                end
            end
            default: eff_s = depth_q;
        endcase
    end

    assign result_s = (eff_s == DEPTH_ZERO) && !frozen_s && !forced_zero_s;

    assign result        = result_s;
    assign depth         = depth_q;
    assign err_unmatched = err_unm_q;
    assign err_overflow  = err_ovf_q;

endmodule

// File: doc/block_nest_checker.md
BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

Interface
REQ-001 SHALL have parameter DEPTH_W, default 8: width of nesting counter.
REQ-002 SHALL have parameter MAX_DEPTH, default 255: highest legal nesting depth, at most 2^DEPTH_W-1.
REQ-003 SHALL have parameter CASE_SENS, default 0: 0 = keywords match case-insensitively, 1 = lowercase only.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1: in carries a character this cycle.
REQ-007 SHALL have port in  input  8: ASCII character.
REQ-008 SHALL have port result  output  1: 1 = stream so far, if terminated now, is balanced and error-free.
REQ-009 SHALL have port depth  output  DEPTH_W: committed nesting depth.
REQ-010 SHALL have port err_unmatched  output  1: sticky, "end" seen at depth 0.
REQ-011 SHALL have port err_overflow  output  1: sticky, "begin" seen at depth MAX_DEPTH.

Function
REQ-012 SHALL consume a character only on rising edges with in_valid=1; in_valid=0 cycles leave all state unchanged.
REQ-013 SHALL treat 8'h20 as the only separator; every other byte is a word character.
REQ-014 SHALL track the current word with FSM states SEP, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER; reset state SEP.
REQ-015 SHALL advance the word FSM along the keyword prefix on each matching letter, go to OTHER on any mismatch or on a letter after BEGIN/END, and stay in OTHER until a separator.
REQ-016 SHALL, on a separator, commit the pending word and return to SEP; consecutive separators commit nothing.
REQ-017 SHALL, committing BEGIN with depth<MAX_DEPTH, set depth=depth+1 one cycle after the separator is consumed.
REQ-018 SHALL, committing BEGIN with depth==MAX_DEPTH, set err_overflow=1 and leave depth unchanged.
REQ-019 SHALL, committing END with depth>0, set depth=depth-1; with depth==0, set err_unmatched=1 and leave depth at 0.
REQ-020 SHALL freeze depth once either error flag is set; errors are cleared only by reset.
REQ-021 SHALL compute result combinationally from committed state plus pending word: eff = depth+1 if FSM==BEGIN, depth-1 if FSM==END and depth>0, else depth; pending END at depth 0 forces result=0; pending BEGIN at MAX_DEPTH forces result=0.
REQ-022 SHALL drive result=1 only when eff==0 and no error flag set and no forced-0 condition holds.
REQ-023 SHALL use DEPTH_W-bit arithmetic with no wrap: increment and decrement are guarded as in REQ-017..019.

Reset
REQ-024 SHALL, on rising clk with reset=0, set word FSM=SEP, depth=0, err_unmatched=0, err_overflow=0; result reads 1.
REQ-025 SHALL give reset priority over in_valid; a reset mid-word discards the partial word.

Structure
REQ-026 SHALL place the word-state enum, ASCII constants (space, B/E/G/I/N/D in both cases) and the keyword-class encoding (NONE, KW_BEGIN, KW_END) in shared package block_chk_pkg.
REQ-027 SHALL implement the word FSM as sub-module kw_matcher (outputs pending class and commit strobe); depth and error logic stay in block_nest_checker.

Verification
REQ-028 Bench SHALL drive "BeGiN end " -> depth 1 after the first space, 0 after the second, result=1 at end, no errors.
REQ-029 Bench SHALL drive "end" with no trailing space -> result=0 while pending; then "s " -> word becomes OTHER, result=1, err_unmatched=0.
REQ-030 Bench SHALL drive "begin begins " -> depth=1, result=0; then "end" (no space) -> result=1 from pending END, depth still 1.
REQ-031 Bench SHALL, with MAX_DEPTH=2, drive "begin begin begin " -> depth=2, err_overflow=1, result=0; a later "end end " leaves depth=2 (frozen).
REQ-032 Bench SHALL drive "end begin " -> err_unmatched=1 after first space, depth stays 0, result=0 thereafter; reset=0 one cycle -> all outputs back to reset values.
REQ-033 Bench SHALL interleave in_valid=0 cycles inside "beg_in " (gap at '_' position) -> identical depth=1 to the gapless run; with CASE_SENS=1, "BEGIN " -> depth 0.
